// File: rtl/axi4_pkg.sv
// Shared AXI4 read-channel types: burst/response encodings, the AR request record
// and the read-slave FSM state.
package axi4_pkg;

    localparam int AXI_ID_W_MAX = 16;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_ID_W_MAX-1:0] id;
        logic [31:0]             addr;
        logic [7:0]              len;
        logic [2:0]              size;
        axi_burst_e              burst;
    } ar_req_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_e;

endpackage

// File: rtl/axi4_ar_fifo.sv
// Two-entry AR request queue; ready is registered so it is low throughout reset
// and never admits a push while full, even when a pop happens in the same cycle.
module axi4_ar_fifo
    import axi4_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  ar_req_t din,
    input  logic    pop,
    output ar_req_t dout,
    output logic    empty,
    output logic    ready
);

    ar_req_t    slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       ready_q, ready_d;
    logic       do_push, do_pop;

    always_comb begin
        do_push = push && ready_q;
        do_pop  = pop && (count_q != 2'd0);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (do_pop) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
        // count_d here is the occupancy after any pop, so it selects the free slot
        if (do_push) begin
            if (count_d == 2'd0) begin
                slot0_d = din;
            end else begin
                slot1_d = din;
            end
            count_d = count_d + 2'd1;
        end
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign dout  = slot0_q;
    assign empty = (count_q == 2'd0);
    assign ready = ready_q;

endmodule

// File: rtl/axi4_read_pattern_slave.sv
// AXI4 read slave returning address-derived byte patterns (lane j = low byte of A+j).
// Define AXI4_RD_WRAP_EN to accept WRAP bursts of 2/4/8/16 beats; otherwise WRAP is SLVERR.
module axi4_read_pattern_slave
    import axi4_pkg::*;
#(
    parameter int          N     = 4,
    parameter int          I     = 1,
    parameter logic [31:0] LIMIT = 32'h0001_0000
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic [I-1:0]   ARID,
    input  logic [31:0]    ARADDR,
    input  logic [7:0]     ARLEN,
    input  logic [2:0]     ARSIZE,
    input  logic [1:0]     ARBURST,
    input  logic           ARVALID,
    output logic           ARREADY,
    output logic [I-1:0]   RID,
    output logic [8*N-1:0] RDATA,
    output logic [1:0]     RRESP,
    output logic           RLAST,
    output logic           RVALID,
    input  logic           RREADY
);

`ifdef AXI4_RD_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [2:0]  SIZE_LOG2 = 3'($clog2(N));
    localparam logic [31:0] NB        = 32'(N);

    ar_req_t        ar_req, head;
    logic           fifo_pop, fifo_empty, fifo_ready;
    logic           unused_id;
    logic           emit, load;

    rd_state_e      state_q, state_d;
    logic [31:0]    addr_q, addr_d, wmask_q, wmask_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [I-1:0]   id_q, id_d;
    axi_burst_e     burst_q, burst_d;
    logic           berr_q, berr_d;
    logic           rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [8*N-1:0] rdata_q, rdata_d;
    logic [1:0]     rresp_q, rresp_d;

    function automatic logic req_err(input ar_req_t r);
        logic wrap_len_ok;
        wrap_len_ok = (r.len == 8'd1) || (r.len == 8'd3) || (r.len == 8'd7) || (r.len == 8'd15);
        return (r.size != SIZE_LOG2) || (r.burst == BURST_RSVD) ||
               ((r.burst == BURST_WRAP) && !(WRAP_EN && wrap_len_ok));
    endfunction

    // WRAP keeps the bits above the window mask and steps only the bits inside it
    function automatic logic [31:0] next_addr(input logic [31:0] a, input axi_burst_e b,
                                              input logic [31:0] m);
        logic [31:0] n;
        case (b)
            BURST_FIXED: n = a;
            BURST_WRAP:  n = (a & ~m) | ((a + NB) & m);
            default:     n = a + NB;
        endcase
        return n;
    endfunction

    function automatic logic [8*N-1:0] beat_data(input logic [31:0] a);
        logic [8*N-1:0] d;
        d = '0;
        for (int j = 0; j < N; j++) begin
            d[8*j +: 8] = 8'(a + 32'(j));
        end
        return d;
    endfunction

    assign ar_req = '{id: 16'(ARID), addr: ARADDR, len: ARLEN, size: ARSIZE,
                      burst: axi_burst_e'(ARBURST)};
    assign unused_id = ^head.id;

    axi4_ar_fifo u_ar_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (ARVALID),
        .din   (ar_req),
        .pop   (fifo_pop),
        .dout  (head),
        .empty (fifo_empty),
        .ready (fifo_ready)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wmask_d  = wmask_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        burst_d  = burst_q;
        berr_d   = berr_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        fifo_pop = 1'b0;
        emit     = 1'b0;
        load     = 1'b0;

        // The IDLE load leaves RVALID low for one cycle; the back-to-back load emits at once
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!rvalid_q) begin
                    emit = 1'b1;
                end else if (RREADY) begin
                    if (cnt_q != 8'd0) begin
                        addr_d = next_addr(addr_q, burst_q, wmask_q);
                        cnt_d  = cnt_q - 8'd1;
                        emit   = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                        emit = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rresp_d  = RESP_OKAY;
                        rdata_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            addr_d   = head.addr & ~(NB - 32'd1);
            cnt_d    = head.len;
            id_d     = head.id[I-1:0];
            berr_d   = req_err(head);
            burst_d  = ((head.burst == BURST_WRAP) && !WRAP_EN) ? BURST_INCR : head.burst;
            wmask_d  = ((32'(head.len) + 32'd1) * NB) - 32'd1;
        end

        if (emit) begin
            rvalid_d = 1'b1;
            rlast_d  = (cnt_d == 8'd0);
            if (berr_d || (addr_d >= LIMIT)) begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = beat_data(addr_d);
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wmask_q  <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            burst_q  <= BURST_FIXED;
            berr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wmask_q  <= wmask_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            burst_q  <= burst_d;
            berr_q   <= berr_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign ARREADY = fifo_ready;
    assign RID     = id_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi4_read_pattern_slave.sv
// Bench for axi4_read_pattern_slave: directed table, hand sequences, and random traffic
// against a queue-based beat model; honours AXI4_RD_WRAP_EN like the design.
module tb_axi4_read_pattern_slave;

    localparam int          N     = 4;
    localparam int          I     = 4;
    localparam logic [31:0] LIMIT = 32'h0001_0000;
`ifdef AXI4_RD_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [I-1:0] ARID;
    logic [31:0]  ARADDR;
    logic [7:0]   ARLEN;
    logic [2:0]   ARSIZE;
    logic [1:0]   ARBURST;
    logic         ARVALID;
    logic         ARREADY;
    logic [I-1:0] RID;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;

    axi4_read_pattern_slave #(.N(N), .I(I), .LIMIT(LIMIT)) dut (
        .ACLK(clk), .ARESET(rst), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [I-1:0] id;
        logic [31:0]  data;
        logic [1:0]   resp;
        logic         last;
    } exp_t;

    typedef struct {
        logic [I-1:0]     id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  r;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] log_d[$];
    logic [1:0]  log_r[$];
    logic        log_l[$];
    logic [I-1:0] log_id[$];
    int          log_cyc[$];
    vec_t        vecs[7];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rr_mode  = 0;

    logic         hold_v = 1'b0;
    logic [31:0]  hold_d;
    logic [1:0]   hold_r;
    logic         hold_l;
    logic [I-1:0] hold_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: enumerate every beat of a burst from the addressing rules directly
    task automatic model_push(input logic [I-1:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst);
        logic [31:0] a, a0, wsz, base;
        bit          berr, wrap_ok;
        exp_t        e;
        wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        a0   = addr - (addr % 4);
        berr = (size != 3'd2) || (burst == 2'b11) || (burst == 2'b10 && !(WRAP_EN && wrap_ok));
        wsz  = (32'(len) + 1) * 4;
        base = a0 - (a0 % wsz);
        a    = a0;
        for (int k = 0; k <= int'(len); k++) begin
            e.id   = id;
            e.last = (k == int'(len));
            e.resp = (berr || a >= LIMIT) ? 2'b10 : 2'b00;
            e.data = '0;
            if (e.resp == 2'b00)
                for (int j = 0; j < 4; j++) e.data[8*j +: 8] = 8'((a + 32'(j)) % 256);
            exp_q.push_back(e);
            if (burst == 2'b00) a = a;
            else if (burst == 2'b10 && WRAP_EN && wrap_ok) a = base + (a - base + 4) % wsz;
            else a = a + 4;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       RREADY = 1'b1;
            1:       RREADY = (cyc % 3 == 0);
            default: RREADY = 1'($urandom % 2);
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(RVALID), 32'd1);
                chk("stall_data", RDATA, hold_d);
                chk("stall_resp", 32'(RRESP), 32'(hold_r));
                chk("stall_last", 32'(RLAST), 32'(hold_l));
                chk("stall_id", 32'(RID), 32'(hold_id));
            end
            if (ARVALID && ARREADY) model_push(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
            if (RVALID && RREADY) begin
                log_d.push_back(RDATA);
                log_r.push_back(RRESP);
                log_l.push_back(RLAST);
                log_id.push_back(RID);
                log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_unexpected_beat: got data 0x%0h, expected no beat", RDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", RDATA, e.data);
                    chk("sb_resp", 32'(RRESP), 32'(e.resp));
                    chk("sb_last", 32'(RLAST), 32'(e.last));
                    chk("sb_id", 32'(RID), 32'(e.id));
                end
            end
            hold_v  = RVALID && !RREADY;
            hold_d  = RDATA;
            hold_r  = RRESP;
            hold_l  = RLAST;
            hold_id = RID;
        end
    end

    task automatic clear_logs();
        log_d.delete(); log_r.delete(); log_l.delete(); log_id.delete(); log_cyc.delete();
    endtask

    // Call just after a rising edge; returns just after the handshake edge
    task automatic send_ar(input logic [I-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int waited);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (ARREADY) break;
            waited++;
            if (waited > 300) begin
                fail_now("ar_handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int t = 0; t < 1000; t++) begin
            if (log_d.size() >= n) return;
            @(negedge clk);
            #1;
        end
        fail_now("wait_beats");
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            if (exp_q.size() == 0 && !RVALID) return;
            @(negedge clk);
            #1;
        end
        fail_now("wait_idle");
    endtask

    task automatic set_vec(input int i, input logic [I-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3, input logic [1:0] r0, input logic [1:0] r1,
                           input logic [1:0] r2, input logic [1:0] r3);
        vecs[i].id = id; vecs[i].addr = addr; vecs[i].len = len;
        vecs[i].size = size; vecs[i].burst = burst;
        vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2; vecs[i].d[3] = d3;
        vecs[i].r[0] = r0; vecs[i].r[1] = r1; vecs[i].r[2] = r2; vecs[i].r[3] = r3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        set_vec(0, 4'd1, 32'h100, 8'd3, 3'd2, 2'b01,
                32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 2'b00, 2'b00, 2'b00, 2'b00);
        set_vec(1, 4'd2, LIMIT - 32'd8, 8'd3, 3'd2, 2'b01,
                32'hFBFAF9F8, 32'hFFFEFDFC, 32'h0, 32'h0, 2'b00, 2'b00, 2'b10, 2'b10);
`ifdef AXI4_RD_WRAP_EN
        set_vec(2, 4'd3, 32'h108, 8'd3, 3'd2, 2'b10,
                32'h0B0A0908, 32'h0F0E0D0C, 32'h03020100, 32'h07060504, 2'b00, 2'b00, 2'b00, 2'b00);
`else
        set_vec(2, 4'd3, 32'h108, 8'd3, 3'd2, 2'b10,
                32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b10, 2'b10);
`endif
        set_vec(3, 4'd4, 32'h201, 8'd3, 3'd2, 2'b00,
                32'h03020100, 32'h03020100, 32'h03020100, 32'h03020100, 2'b00, 2'b00, 2'b00, 2'b00);
        set_vec(4, 4'd5, 32'h300, 8'd1, 3'd1, 2'b01,
                32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 2'b00);
        set_vec(5, 4'd6, 32'h40, 8'd0, 3'd2, 2'b11,
                32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00);
        set_vec(6, 4'd7, 32'h100, 8'd2, 3'd2, 2'b10,
                32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b10, 2'b00);

        rst = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
        ARBURST = '0; RREADY = 1'b1; rr_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_rid", 32'(RID), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        rst = 1'b0;
        #1;
        chk("arready_before_edge", 32'(ARREADY), 32'd0);
        @(negedge clk);
        chk("arready_first_edge", 32'(ARREADY), 32'd1);

        // First-beat latency from idle
        @(posedge clk); #1;
        send_ar(4'd9, 32'h0, 8'd0, 3'd2, 2'b01, w);
        @(negedge clk); chk("lat_edge0", 32'(RVALID), 32'd0);
        @(negedge clk); chk("lat_edge1", 32'(RVALID), 32'd0);
        @(negedge clk); chk("lat_edge2", 32'(RVALID), 32'd1);
        wait_idle();

        for (int v = 0; v < 7; v++) begin
            clear_logs();
            @(posedge clk); #1;
            send_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, w);
            wait_beats(int'(vecs[v].len) + 1);
            wait_idle();
            for (int k = 0; k <= int'(vecs[v].len) && k < 4 && k < log_d.size(); k++) begin
                chk($sformatf("vec%0d_data%0d", v, k), log_d[k], vecs[v].d[k]);
                chk($sformatf("vec%0d_resp%0d", v, k), 32'(log_r[k]), 32'(vecs[v].r[k]));
                chk($sformatf("vec%0d_last%0d", v, k), 32'(log_l[k]), 32'(k == int'(vecs[v].len)));
            end
            chk($sformatf("vec%0d_beats", v), 32'(log_d.size()), 32'(int'(vecs[v].len) + 1));
        end

        // Back-to-back single-beat requests
        clear_logs();
        @(posedge clk); #1;
        send_ar(4'd0, 32'h10, 8'd0, 3'd2, 2'b01, w);
        chk("b2b_ar0_wait", 32'(w), 32'd0);
        send_ar(4'd1, 32'h20, 8'd0, 3'd2, 2'b01, w);
        chk("b2b_ar1_wait", 32'(w), 32'd0);
        wait_beats(2);
        wait_idle();
        if (log_d.size() >= 2) begin
            chk("b2b_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
            chk("b2b_id0", 32'(log_id[0]), 32'd0);
            chk("b2b_id1", 32'(log_id[1]), 32'd1);
            chk("b2b_last0", 32'(log_l[0]), 32'd1);
            chk("b2b_last1", 32'(log_l[1]), 32'd1);
        end

        // Stalled long burst fills the queue
        rr_mode = 1;
        @(posedge clk); #1;
        send_ar(4'd1, 32'h800, 8'd7, 3'd2, 2'b01, w);
        send_ar(4'd2, 32'h900, 8'd1, 3'd2, 2'b01, w);
        send_ar(4'd3, 32'hA00, 8'd0, 3'd2, 2'b00, w);
        chk("arready_full", 32'(ARREADY), 32'd0);
        send_ar(4'd4, 32'hB00, 8'd2, 3'd2, 2'b01, w);
        chk("ar_backpressured", 32'(w != 0), 32'd1);
        wait_idle();

        // Random traffic
        rr_mode = 2;
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            logic [7:0]  len;
            logic [2:0]  sz;
            case ($urandom % 4)
                0:       a = LIMIT - 32'd16 + ($urandom % 32);
                1:       a = 32'hFFFF_FFF0 + ($urandom % 16);
                default: a = $urandom % 32'h2000;
            endcase
            len = ($urandom % 6 == 0) ? 8'd15 : 8'($urandom % 8);
            sz  = ($urandom % 5 == 0) ? 3'($urandom % 4) : 3'd2;
            repeat ($urandom % 3) begin @(posedge clk); #1; end
            send_ar(4'($urandom), a, len, sz, 2'($urandom), w);
        end
        wait_idle();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a burst with one request queued
        rr_mode = 0;
        clear_logs();
        @(posedge clk); #1;
        send_ar(4'd5, 32'h400, 8'd7, 3'd2, 2'b01, w);
        send_ar(4'd6, 32'h600, 8'd2, 3'd2, 2'b01, w);
        wait_beats(1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(RVALID), 32'd0);
        chk("midrst_arready", 32'(ARREADY), 32'd0);
        chk("midrst_rdata", RDATA, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (10) @(negedge clk);
        chk("midrst_no_beats", 32'(log_d.size()), 32'd0);
        chk("midrst_idle", 32'(RVALID), 32'd0);
        @(posedge clk); #1;
        send_ar(4'd3, 32'h500, 8'd1, 3'd2, 2'b01, w);
        wait_beats(2);
        wait_idle();
        if (log_d.size() >= 2) begin
            chk("postrst_beat1", log_d[0], 32'h03020100);
            chk("postrst_beat2", log_d[1], 32'h07060504);
            chk("postrst_id", 32'(log_id[0]), 32'd3);
        end
        chk("postrst_beats", 32'(log_d.size()), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
